// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by fetch and data stages.
// Data side has priority; a streak limit keeps fetch moving.
module mem_port_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int WAIT_CYCLES  = 2,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_d,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);
  localparam logic [SW-1:0] STRK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic              own_d;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     strk_q, strk_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              d_wins;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      strk_q  <= '0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      strk_q  <= strk_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  assign d_wins = d_req &
    (~if_req | (strk_q != STRK_MAX));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strk_d  = strk_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          state_d = ACCESS;
          cnt_d   = '0;
          if (d_wins) begin
            req_d = '{own_d: 1'b1, we: d_we,
                      addr: d_addr, wdata: d_wdata};
            if (!if_req)
              strk_d = '0;
            else if (strk_q != STRK_MAX)
              strk_d = strk_q + 1'b1;
          end else begin
            req_d = '{own_d: 1'b0, we: 1'b0,
                      addr: if_addr, wdata: '0};
            strk_d = '0;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          if (!req_q.we)
            rdata_d = mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign if_valid  = (state_q == RESP) & ~req_q.own_d;
  assign d_valid   = (state_q == RESP) & req_q.own_d;
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;
  assign stall_if  = if_req & ~if_valid;
  assign stall_d   = d_req & ~d_valid;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the fetch stage (read-only) and the memory stage (load/store, driven by the MemRead/MemWrite decode outputs).
- Grants one requester at a time, holds the memory for a fixed wait-state count, and returns data with a one-cycle valid pulse.
- Drives stall signals back to the pipeline.
- Data side has priority; a streak counter guarantees fetch forward progress.

Parameters:
- ADDR_W, 9, word address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 2, extra cycles memory needs after first enabled cycle (≥0).
- MAX_D_STREAK, 4, consecutive contested data grants before fetch is forced (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held until if_valid.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_valid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  read data (meaningful only with if_valid).
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_valid  out  1  one-cycle completion pulse (loads and stores).
- d_rdata  out  DATA_W  load data.
- stall_if  out  1  if_req & ~if_valid (combinational).
- stall_d  out  1  d_req & ~d_valid (combinational).
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in last ACCESS cycle.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state = IDLE; cnt = 0; d_streak = 0.
  - mem_en, mem_we, if_valid, d_valid = 0.
  - mem_addr, mem_wdata, rdata register = 0.
  - stall_* follow inputs.
  - An interrupted access is abandoned; a partially applied store is not retried by the arbiter. Requesters reissue after reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, at clock edge with any req:
  - Pick owner and latch owner, addr, we, wdata (fetch: we = 0).
  - cnt = 0; go ACCESS.
  - With no req, stay IDLE.
- Arbitration (IDLE only):
  - Only one requester: it wins.
  - Both requesting: data wins unless d_streak == MAX_D_STREAK, in which case fetch wins.
- d_streak:
  - Data grant with if_req high: +1 (saturates at MAX_D_STREAK).
  - Data grant with if_req low: 0.
  - Fetch grant: 0.
- ACCESS:
  - mem_en = 1; mem_we = latched we; mem_addr/mem_wdata from latched registers, stable all ACCESS cycles.
  - cnt increments each edge.
  - At edge where cnt == WAIT_CYCLES: capture mem_rdata into rdata register (reads only; writes leave it unchanged); go RESP.
- RESP:
  - mem_en = mem_we = 0.
  - Owner's valid = 1 for exactly this cycle.
  - if_rdata and d_rdata both driven from the rdata register.
  - Next edge → IDLE unconditionally.
- Timing:
  - Req sampled at edge E0 → ACCESS for WAIT_CYCLES+1 cycles → valid high in cycle after edge E0+WAIT_CYCLES+1.
  - Throughput: one access per WAIT_CYCLES+3 cycles.
- Requester may change or drop req at the edge ending its valid cycle. The RESP→IDLE step guarantees the new req value is sampled, never the stale one.
- Request changes or drops mid-access are ignored: latched values are used. A dropped request still completes and still pulses valid.
- Non-owner req arriving during ACCESS/RESP waits; its stall stays high.
- Never both valids in one cycle. Never mem_en in IDLE/RESP.

Test Plan (WAIT_CYCLES=2, MAX_D_STREAK=4):
- Single fetch: reset release, if_req=1, if_addr=0x010 sampled at E0, mem_rdata=0xDEADBEEF during cycles after E0..E2 → mem_en high 3 cycles with mem_addr=0x010, mem_we=0; if_valid=1, if_rdata=0xDEADBEEF in cycle after E3; stall_if low only then.
- Store: d_req=1, d_we=1, d_addr=0x020, d_wdata=0x12345678 → mem_we=1 for 3 cycles; d_valid pulse at E3; if_rdata/d_rdata unchanged from prior value.
- Contention: if_req and d_req both high at E0 → data served first (valid at E3); fetch sampled at E5, if_valid at E8.
- Starvation guard: if_req held high and d_req re-asserted each time → 4 data grants, then fetch granted 5th, d_streak back to 0; next contested grant goes to data.
- Mid-access changes: change d_addr to 0x030 during ACCESS, then drop d_req → mem_addr stays 0x020, d_valid still pulses once.
- Reset mid-ACCESS: assert reset at cycle after E1 → mem_en/mem_we drop same cycle without clock edge, no valid ever pulses; after release a held req restarts from IDLE with full 3-cycle ACCESS.
